eth_ingress_arbiter: RTL and testbench
======================================

Name: eth_ingress_arbiter

Overview:
- Shares one ethernet_ipv4_handler between two byte-wide AXI4-Stream ingress ports.
- Grants are per frame, round-robin. A grant is held from the first beat through the beat with tlast set.
- After each frame, waits for the handler's metadata handshake and tags the metadata with the source port.
- Keeps per-port frame counters and a timeout counter. The timeout covers frames the handler silently drops on a bad IPv4 checksum, which produce no metadata.

Parameters:
DATA_WIDTH, 8, stream byte width; must match the handler.
TIMEOUT_CYCLES, 64, cycles to wait for handler metadata after a frame's last beat (1..255).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s0_tdata  in  DATA_WIDTH  port 0 data
s0_tvalid  in  1  port 0 valid
s0_tlast  in  1  port 0 end of frame
s0_tready  out  1  port 0 ready
s1_tdata  in  DATA_WIDTH  port 1 data
s1_tvalid  in  1  port 1 valid
s1_tlast  in  1  port 1 end of frame
s1_tready  out  1  port 1 ready
m_tdata  out  DATA_WIDTH  data to handler slave
m_tvalid  out  1  valid to handler
m_tlast  out  1  tlast to handler
m_tready  in  1  handler tready
hdl_meta_valid  in  1  handler meta_valid
hdl_meta_ready  out  1  handler meta_ready
meta_valid  out  1  tagged metadata valid downstream
meta_ready  in  1  downstream accept
meta_port  out  1  source port of the current metadata
frames_p0  out  16  frames completed with metadata, port 0 (saturating)
frames_p1  out  16  frames completed with metadata, port 1 (saturating)
timeouts  out  16  frames that ended by timeout (saturating)
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, grant=0, last_grant=1 (so port 0 wins first), timer=0, all counters 0. With the combinational rules below, every output is 0 during reset.
- States: IDLE, STREAM, WAIT_META.
- IDLE:
  - If exactly one sX_tvalid is high, grant that port.
  - If both are high, grant !last_grant.
  - Grant is registered; go to STREAM next cycle. The first beat therefore passes through 1 cycle after a request (0 data latency after grant).
  - All tready low, m_tvalid=0.
- STREAM (combinational mux on the granted port):
  - m_tdata, m_tvalid and m_tlast follow the granted port; s_grant_tready=m_tready. The non-granted port's tready is held 0.
  - Accepted beat with tlast (valid && ready && tlast): go to WAIT_META, timer=0, last_grant=grant.
  - tvalid gaps mid-frame keep the grant; no preemption.
- WAIT_META:
  - All tready=0, m_tvalid=0.
  - meta_valid=hdl_meta_valid; meta_port=grant.
  - hdl_meta_ready=meta_ready && hdl_meta_valid.
  - hdl_meta_valid && meta_ready: increment frames_p{grant}, go to IDLE.
  - Otherwise timer increments each cycle. When timer reaches TIMEOUT_CYCLES-1 with no handshake, increment timeouts and go to IDLE.
  - A handshake in the same cycle as the timeout takes priority: counts as a frame, not a timeout.
- Outside WAIT_META: meta_valid=0 and hdl_meta_ready=0, regardless of hdl_meta_valid.
- Counters saturate at 0xFFFF; there is no wrap.
- New requests during STREAM or WAIT_META are held off (tready=0). They are arbitrated on return to IDLE, which lasts 1 cycle minimum between frames.
- rst_n asserted mid-frame: immediate return to reset values; a partial frame is abandoned with no tlast emitted.
- m_tlast is only meaningful when m_tvalid=1 and is 0 outside STREAM.

Test Plan:
- Single frame on port 0 (20 bytes, tlast on byte 20), m_tready=1, handler raises meta after frame, meta_ready=1 → 20 beats on m_*; meta_valid with meta_port=0 for 1 cycle; frames_p0=1; state back to IDLE.
- Both ports request continuously with 3-byte frames each → grants alternate 0,1,0,1. s1_tready stays 0 throughout port 0's frame; after 4 frames frames_p0=2, frames_p1=2.
- Frame on port 1, hdl_meta_valid never asserted, TIMEOUT_CYCLES=64 → IDLE exactly 64 cycles after the tlast beat; timeouts=1; frames_p1=0; meta_valid never high.
- Backpressure: m_tready toggles 1/0 and s0_tvalid has gaps mid-frame → no beat duplicated or lost; byte sequence on m_tdata equals input; grant never switches before tlast.
- Downstream stall: hdl_meta_valid=1, meta_ready=0 for 10 cycles, then 1 → hdl_meta_ready=0 for those 10 cycles, then 1 for one cycle; meta_port stable throughout; one count added.
- rst_n pulled low on byte 5 of a port 0 frame → all outputs 0 during reset; after release, a fresh port 1 request is granted normally and counters read 0.

Source files
------------

// File: rtl/eth_ingress_arbiter.sv
// Per-frame round-robin arbiter sharing one ethernet_ipv4_handler between two
// byte-wide AXI4-Stream ingress ports; tags handler metadata with its source port.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_IDLE      | no frame in flight; arbitrate pending requests into grant
// ST_STREAM    | granted port passes through to the handler until its tlast beat
// ST_WAIT_META | frame done; wait for handler metadata or timeout
module eth_ingress_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic                  s0_tvalid,
    input  logic                  s0_tlast,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic                  s1_tvalid,
    input  logic                  s1_tlast,
    output logic                  s1_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    input  logic                  hdl_meta_valid,
    output logic                  hdl_meta_ready,
    output logic                  meta_valid,
    input  logic                  meta_ready,
    output logic                  meta_port,
    output logic [15:0]           frames_p0,
    output logic [15:0]           frames_p1,
    output logic [15:0]           timeouts,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STREAM    = 2'd1,
        ST_WAIT_META = 2'd2
    } state_t;

    localparam logic [7:0]  TIMER_TC = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    state_t                state, state_nxt;
    logic                  grant, grant_nxt;
    logic                  last_grant, last_grant_nxt;
    logic [7:0]            timer, timer_nxt;
    logic                  inc_p0, inc_p1, inc_to;

    logic [DATA_WIDTH-1:0] sel_tdata;
    logic                  sel_tvalid;
    logic                  sel_tlast;
    logic                  last_beat;
    logic                  meta_hs;
    logic                  timer_tc;

    assign sel_tdata  = grant ? s1_tdata  : s0_tdata;
    assign sel_tvalid = grant ? s1_tvalid : s0_tvalid;
    assign sel_tlast  = grant ? s1_tlast  : s0_tlast;

    assign last_beat = (state == ST_STREAM) && sel_tvalid && m_tready && sel_tlast;
    assign meta_hs   = (state == ST_WAIT_META) && hdl_meta_valid && meta_ready;
    assign timer_tc  = (timer == TIMER_TC);

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            timer      <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            timer      <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        timer_nxt      = timer;
        inc_p0         = 1'b0;
        inc_p1         = 1'b0;
        inc_to         = 1'b0;
        s0_tready      = 1'b0;
        s1_tready      = 1'b0;
        m_tdata        = '0;
        m_tvalid       = 1'b0;
        m_tlast        = 1'b0;
        meta_valid     = 1'b0;
        meta_port      = 1'b0;
        hdl_meta_ready = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (s0_tvalid || s1_tvalid) begin
                    // Contention goes to the port that did not carry the previous frame.
                    grant_nxt = (s0_tvalid && s1_tvalid) ? ~last_grant : s1_tvalid;
                    state_nxt = ST_STREAM;
                end
            end

            ST_STREAM: begin
                m_tdata   = sel_tdata;
                m_tvalid  = sel_tvalid;
                m_tlast   = sel_tvalid && sel_tlast;
                s0_tready = !grant && m_tready;
                s1_tready = grant && m_tready;
                if (last_beat) begin
                    state_nxt      = ST_WAIT_META;
                    timer_nxt      = '0;
                    last_grant_nxt = grant;
                end
            end

            ST_WAIT_META: begin
                meta_valid     = hdl_meta_valid;
                meta_port      = grant;
                hdl_meta_ready = meta_ready && hdl_meta_valid;
                // A handshake on the timeout cycle still counts as a completed frame.
                if (meta_hs) begin
                    inc_p0    = !grant;
                    inc_p1    = grant;
                    state_nxt = ST_IDLE;
                end else if (timer_tc) begin
                    inc_to    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_p0 <= '0;
            frames_p1 <= '0;
            timeouts  <= '0;
        end else begin
            if (inc_p0 && (frames_p0 != CNT_MAX)) frames_p0 <= frames_p0 + 16'd1;
            if (inc_p1 && (frames_p1 != CNT_MAX)) frames_p1 <= frames_p1 + 16'd1;
            if (inc_to && (timeouts  != CNT_MAX)) timeouts  <= timeouts  + 16'd1;
        end
    end

endmodule

// File: tb/tb_eth_ingress_arbiter.sv
// Randomized self-checking bench for eth_ingress_arbiter: frame-level queues per
// port, round-robin order prediction, handler/downstream models and counter totals.
module tb_eth_ingress_arbiter;

    localparam int DW = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic          s0_tvalid, s0_tlast, s0_tready;
    logic          s1_tvalid, s1_tlast, s1_tready;
    logic          m_tvalid, m_tlast, m_tready;
    logic          hdl_meta_valid, hdl_meta_ready;
    logic          meta_valid, meta_ready, meta_port;
    logic [15:0]   frames_p0, frames_p1, timeouts;
    logic          busy;

    always #5 clk = ~clk;

    eth_ingress_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .hdl_meta_valid(hdl_meta_valid), .hdl_meta_ready(hdl_meta_ready),
        .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_port(meta_port),
        .frames_p0(frames_p0), .frames_p1(frames_p1), .timeouts(timeouts), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Beats stored as {last, data}: src_q feeds the ports, exp_q is what the handler must see.
    logic [8:0] src_q [2][$];
    logic [8:0] exp_q [2][$];

    logic       sv [2];
    logic [7:0] sd [2];
    logic       sl [2];
    bit         first_beat [2];

    int  gap_pct, rdy_pct, drop_pct, delay_max, stall_fixed;
    bit  noise;
    bit  in_frame, waiting, chk_idle, hp;
    int  cur_port, last_port, wait_cnt, delay_cnt, stall_len, stall_cnt, beats_run;
    logic hv;
    int  exp_p0, exp_p1, exp_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
            sv[p] = 1'b0;
            sd[p] = '0;
            sl[p] = 1'b0;
            first_beat[p] = 1'b1;
        end
        in_frame = 0; waiting = 0; chk_idle = 0; hp = 0; hv = 1'b0;
        cur_port = 0; last_port = 1; wait_cnt = 0; delay_cnt = 0;
        stall_len = 0; stall_cnt = 0; beats_run = 0;
        exp_p0 = 0; exp_p1 = 0; exp_to = 0;
    endtask

    task automatic add_frame(input int p, input int len);
        logic [8:0] b;
        for (int i = 0; i < len; i++) begin
            b = {(i == len - 1), 8'($urandom_range(255))};
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_m_tdata"}, 32'(m_tdata), 32'(0));
        chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'(0));
        chk({tag, "_m_tlast"}, 32'(m_tlast), 32'(0));
        chk({tag, "_treadys"}, 32'({s1_tready, s0_tready}), 32'(0));
        chk({tag, "_hdl_meta_ready"}, 32'(hdl_meta_ready), 32'(0));
        chk({tag, "_meta_valid"}, 32'(meta_valid), 32'(0));
        chk({tag, "_meta_port"}, 32'(meta_port), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_frames_p0"}, 32'(frames_p0), 32'(exp_p0));
        chk({tag, "_frames_p1"}, 32'(frames_p1), 32'(exp_p1));
        chk({tag, "_timeouts"}, 32'(timeouts), 32'(exp_to));
    endtask

    // One clock: drive at negedge, then check what the next posedge will capture.
    task automatic step();
        logic [8:0] e;
        logic       st;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (!sv[p] && src_q[p].size() > 0 &&
                (first_beat[p] || int'($urandom_range(99)) >= gap_pct)) begin
                sv[p] = 1'b1;
                {sl[p], sd[p]} = src_q[p][0];
            end
        end
        s0_tvalid = sv[0]; s0_tdata = sd[0]; s0_tlast = sl[0];
        s1_tvalid = sv[1]; s1_tdata = sd[1]; s1_tlast = sl[1];
        m_tready = (int'($urandom_range(99)) < rdy_pct);
        if (hp) begin
            if (!hv) begin
                if (delay_cnt == 0) hv = 1'b1;
                else delay_cnt--;
            end
        end else if (!waiting && noise) begin
            hv = 1'($urandom_range(1));
        end else begin
            hv = 1'b0;
        end
        hdl_meta_valid = hv;
        if (hv && waiting) meta_ready = (stall_cnt >= stall_len);
        else meta_ready = 1'($urandom_range(1));
        #1;

        if (chk_idle) begin
            chk("idle_after_frame", 32'(busy), 32'(0));
            chk_idle = 0;
        end
        chk("tready_exclusive", 32'(s0_tready & s1_tready), 32'(0));
        chk("meta_valid", 32'(meta_valid), 32'(waiting && hv));
        chk("hdl_meta_ready", 32'(hdl_meta_ready), 32'(waiting && hv && meta_ready));
        if (waiting) begin
            chk("busy_wait", 32'(busy), 32'(1));
            chk("m_tvalid_wait", 32'(m_tvalid), 32'(0));
            chk("treadys_wait", 32'({s1_tready, s0_tready}), 32'(0));
            if (hv) chk("meta_port", 32'(meta_port), 32'(cur_port));
        end

        if (!waiting && !in_frame && m_tvalid) begin
            if (exp_q[0].size() > 0 && exp_q[1].size() > 0) cur_port = 1 - last_port;
            else cur_port = (exp_q[1].size() > 0) ? 1 : 0;
            if (exp_q[cur_port].size() == 0) chk("spurious_beat", 32'(m_tvalid), 32'(0));
            else in_frame = 1;
        end

        if (waiting) begin
            if (hv && meta_ready) begin
                if (cur_port == 1) exp_p1++;
                else exp_p0++;
                waiting = 0; hp = 0; hv = 1'b0; chk_idle = 1;
            end else begin
                if (hv) stall_cnt++;
                wait_cnt++;
                if (wait_cnt == TO) begin
                    exp_to++;
                    waiting = 0; hp = 0; hv = 1'b0; chk_idle = 1;
                end
            end
        end

        if (in_frame) begin
            st = (cur_port == 1) ? s1_tready : s0_tready;
            chk("tready_granted", 32'(st), 32'(m_tready));
            chk("tready_other", 32'((cur_port == 1) ? s0_tready : s1_tready), 32'(0));
            chk("m_tvalid_follow", 32'(m_tvalid), 32'(sv[cur_port]));
            chk("busy_stream", 32'(busy), 32'(1));
            if (m_tvalid) begin
                chk("m_tdata", 32'(m_tdata), 32'(exp_q[cur_port][0][7:0]));
                chk("m_tlast", 32'(m_tlast), 32'(exp_q[cur_port][0][8]));
            end
            if (m_tvalid && m_tready) begin
                e = exp_q[cur_port].pop_front();
                beats_run++;
                if (e[8]) begin
                    in_frame = 0; waiting = 1; wait_cnt = 0; last_port = cur_port;
                    hp = (int'($urandom_range(99)) >= drop_pct);
                    delay_cnt = int'($urandom_range(delay_max));
                    stall_len = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(4));
                    stall_cnt = 0; hv = 1'b0;
                end
            end
        end

        for (int p = 0; p < 2; p++) begin
            if (sv[p] && ((p == 0) ? s0_tready : s1_tready)) begin
                void'(src_q[p].pop_front());
                first_beat[p] = sl[p];
                sv[p] = 1'b0;
            end
        end
    endtask

    task automatic run(input string tag, input int max_cyc, input int stop_beats);
        int c;
        c = 0;
        beats_run = 0;
        while ((src_q[0].size() > 0 || src_q[1].size() > 0 || in_frame || waiting || chk_idle)
               && c < max_cyc && !(stop_beats > 0 && beats_run >= stop_beats)) begin
            step();
            c++;
        end
        n_tests++;
        assert (c < max_cyc) else begin
            n_fail++;
            $error("FAIL %s_budget cycles=%0d limit=%0d", tag, c, max_cyc);
        end
    endtask

    initial begin
        s0_tdata = '0; s0_tvalid = 1'b0; s0_tlast = 1'b0;
        s1_tdata = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
        m_tready = 1'b0; hdl_meta_valid = 1'b0; meta_ready = 1'b0;
        model_reset();
        gap_pct = 0; rdy_pct = 100; drop_pct = 0; delay_max = 0; stall_fixed = 0; noise = 0;

        // Reset: outputs zero even with requests and metadata pending
        repeat (3) @(negedge clk);
        s0_tvalid = 1'b1; s1_tvalid = 1'b1; hdl_meta_valid = 1'b1; meta_ready = 1'b1; m_tready = 1'b1;
        #1 check_zero("reset");
        check_counters("reset");
        @(negedge clk);
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; hdl_meta_valid = 1'b0;
        rst_n = 1'b1;
        #1 check_zero("post_reset");

        // Single 20-byte frame on port 0
        delay_max = 3;
        add_frame(0, 20);
        run("single", 200, 0);
        check_counters("single");

        // Both ports contending with 3-byte frames
        delay_max = 0;
        add_frame(0, 3); add_frame(0, 3);
        add_frame(1, 3); add_frame(1, 3);
        run("alternate", 200, 0);
        check_counters("alternate");

        // Handler drops the frame: timeout
        drop_pct = 100;
        add_frame(1, 5);
        run("timeout", 300, 0);
        check_counters("timeout");

        // Backpressure and source gaps
        drop_pct = 0; gap_pct = 40; rdy_pct = 50; delay_max = 2;
        add_frame(0, 12); add_frame(1, 7); add_frame(0, 1);
        run("backpressure", 600, 0);
        check_counters("backpressure");

        // Downstream stall of 10 cycles
        gap_pct = 0; rdy_pct = 100; delay_max = 0; stall_fixed = 10;
        add_frame(0, 4);
        run("stall", 200, 0);
        check_counters("stall");

        // Randomized mix
        gap_pct = 30; rdy_pct = 70; drop_pct = 25; delay_max = 5; stall_fixed = -1; noise = 1;
        for (int i = 0; i < 16; i++) add_frame(int'($urandom_range(1)), int'($urandom_range(1, 10)));
        run("random", 20000, 0);
        check_counters("random");

        // Reset in the middle of a port 0 frame, while byte 5 is presented
        gap_pct = 0; rdy_pct = 100; drop_pct = 0; delay_max = 0; stall_fixed = 0; noise = 0;
        add_frame(0, 10);
        run("pre_reset", 100, 4);
        @(negedge clk);
        rst_n = 1'b0;
        s0_tvalid = 1'b1; hdl_meta_valid = 1'b1; meta_ready = 1'b1;
        #1 check_zero("mid_reset");
        model_reset();
        @(negedge clk);
        s0_tvalid = 1'b0; hdl_meta_valid = 1'b0;
        rst_n = 1'b1;
        #1 check_counters("after_reset");
        add_frame(1, 6);
        run("after_reset", 200, 0);
        check_counters("after_reset_frame");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
